gdma_reg_bank: RTL and testbench

GDMA_REG_BANK -- requirements
Module: gdma_reg_bank

---
 rtl/gdma_reg_if.sv | 25 ++
 rtl/gdma_reg_bank.sv | 232 +++++++++++++++++++++++
 tb/tb_gdma_reg_bank.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/gdma_reg_if.sv
// Register access bus between the Zynq PS bridge and the GDMA register bank.
// The master drives address, data, enable and byte enables; the slave returns registered read data.
interface gdma_reg_if;
    logic [12:0] zynq2gdma_reg_addr;
    logic [31:0] zynq2gdma_reg_wrdata;
    logic [31:0] zynq2gdma_reg_rddata;
    logic        zynq2gdma_reg_en;
    logic [3:0]  zynq2gdma_reg_we;

    modport master (
        output zynq2gdma_reg_addr,
        output zynq2gdma_reg_wrdata,
        output zynq2gdma_reg_en,
        output zynq2gdma_reg_we,
        input  zynq2gdma_reg_rddata
    );

    modport slave (
        input  zynq2gdma_reg_addr,
        input  zynq2gdma_reg_wrdata,
        input  zynq2gdma_reg_en,
        input  zynq2gdma_reg_we,
        output zynq2gdma_reg_rddata
    );
endinterface

// File: rtl/gdma_reg_bank.sv
// GDMA control/status register bank: per-channel address/length config, start/done
// handshake with busy tracking and sticky completion flags, global irq/speed/bypass words.
module gdma_reg_bank #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 49
) (
    input  logic                     zynq2gdma_reg_clk,
    input  logic                     zynq2gdma_reg_rst,
    gdma_reg_if.slave                reg_bus,
    output logic [NUM_CH*ADDR_W-1:0] gdma_start_rd_addr,
    output logic [NUM_CH*ADDR_W-1:0] gdma_start_wr_addr,
    output logic [NUM_CH*32-1:0]     gdma_rd_length,
    output logic [NUM_CH*32-1:0]     gdma_wr_length,
    output logic [NUM_CH-1:0]        gdma_rd_start,
    output logic [NUM_CH-1:0]        gdma_wr_start,
    input  logic [NUM_CH-1:0]        gdma_rd_done,
    input  logic [NUM_CH-1:0]        gdma_wr_done,
    output logic [31:0]              gdma_speed_divider,
    output logic                     gdma_package_bypass,
    output logic                     gdma_irq
);

    localparam int          HI_W        = ADDR_W - 32;
    localparam logic [31:0] VERSION     = 32'h0002_0000 | 32'(NUM_CH);
    localparam logic [31:0] CH_MASK     = (32'd1 << NUM_CH) - 32'd1;
    localparam logic [31:0] IRQ_EN_MASK = (CH_MASK << 16) | CH_MASK;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] hi_zext(input logic [HI_W-1:0] v);
        logic [31:0] res;
        res          = 32'd0;
        res[HI_W-1:0] = v;
        return res;
    endfunction

    logic [31:0]     rd_addr_lo_r [NUM_CH];
    logic [HI_W-1:0] rd_addr_hi_r [NUM_CH];
    logic [31:0]     rd_len_r     [NUM_CH];
    logic [31:0]     wr_addr_lo_r [NUM_CH];
    logic [HI_W-1:0] wr_addr_hi_r [NUM_CH];
    logic [31:0]     wr_len_r     [NUM_CH];
    logic [31:0]     irq_en_r;
    logic [31:0]     speed_div_r;
    logic            bypass_r;
    logic [31:0]     rddata_r;

    logic [NUM_CH-1:0] rd_busy_r, wr_busy_r, rd_sticky_r, wr_sticky_r;
    logic [NUM_CH-1:0] rd_start_r, wr_start_r;
    logic              irq_r;

    logic [9:0]        word_s;
    logic [2:0]        off_s;
    logic [4:0]        ch_s;
    logic              wr_s, ch_valid_s;
    logic [NUM_CH-1:0] sel_s, rd_start_req_s, wr_start_req_s, rd_w1c_s, wr_w1c_s;
    logic [NUM_CH-1:0] rd_accept_s, wr_accept_s;
    logic [NUM_CH-1:0] rd_busy_nxt_s, wr_busy_nxt_s, rd_sticky_nxt_s, wr_sticky_nxt_s;
    logic [NUM_CH-1:0] rd_start_nxt_s, wr_start_nxt_s;
    logic              irq_nxt_s;
    logic [31:0]       wdata_s, rd_mux_s, chan_word_s, glob_word_s;
    logic              unused_addr_s;

    assign unused_addr_s = ^{reg_bus.zynq2gdma_reg_addr[12], reg_bus.zynq2gdma_reg_addr[1:0], ch_s[4]};

    // Address decode and per-channel strobes for ctrl / status writes
    always_comb begin
        word_s         = reg_bus.zynq2gdma_reg_addr[11:2];
        off_s          = word_s[2:0];
        ch_s           = {1'b0, word_s[6:3]};
        wdata_s        = reg_bus.zynq2gdma_reg_wrdata;
        wr_s           = reg_bus.zynq2gdma_reg_en & (|reg_bus.zynq2gdma_reg_we);
        ch_valid_s     = (word_s[9:7] == 3'd0) && (ch_s < 5'(NUM_CH));
        sel_s          = '0;
        rd_start_req_s = '0;
        wr_start_req_s = '0;
        rd_w1c_s       = '0;
        wr_w1c_s       = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sel_s[c]          = ch_valid_s && (ch_s == 5'(c));
            rd_start_req_s[c] = wr_s && sel_s[c] && (off_s == 3'd6) && reg_bus.zynq2gdma_reg_we[0] && wdata_s[0];
            wr_start_req_s[c] = wr_s && sel_s[c] && (off_s == 3'd6) && reg_bus.zynq2gdma_reg_we[0] && wdata_s[1];
            rd_w1c_s[c]       = wr_s && sel_s[c] && (off_s == 3'd7) && reg_bus.zynq2gdma_reg_we[0] && wdata_s[2];
            wr_w1c_s[c]       = wr_s && sel_s[c] && (off_s == 3'd7) && reg_bus.zynq2gdma_reg_we[0] && wdata_s[3];
        end
        // done is applied before the start check, so done+start in one cycle is accepted
        rd_accept_s = rd_start_req_s & ~(rd_busy_r & ~gdma_rd_done);
        wr_accept_s = wr_start_req_s & ~(wr_busy_r & ~gdma_wr_done);
    end

    // Channel FSM next state: IDLE/BUSY per direction plus sticky done (set wins over W1C)
    always_comb begin
        rd_busy_nxt_s   = (rd_busy_r & ~gdma_rd_done) | rd_accept_s;
        wr_busy_nxt_s   = (wr_busy_r & ~gdma_wr_done) | wr_accept_s;
        rd_sticky_nxt_s = (rd_sticky_r & ~rd_w1c_s) | gdma_rd_done;
        wr_sticky_nxt_s = (wr_sticky_r & ~wr_w1c_s) | gdma_wr_done;
    end

    // Channel FSM outputs: start pulses and interrupt level, both registered below
    always_comb begin
        rd_start_nxt_s = rd_accept_s;
        wr_start_nxt_s = wr_accept_s;
        irq_nxt_s      = |((rd_sticky_r & irq_en_r[NUM_CH-1:0]) |
                           (wr_sticky_r & irq_en_r[16 +: NUM_CH]));
    end

    // Channel FSM state register
    always_ff @(posedge zynq2gdma_reg_clk or posedge zynq2gdma_reg_rst) begin
        if (zynq2gdma_reg_rst) begin
            rd_busy_r   <= '0;
            wr_busy_r   <= '0;
            rd_sticky_r <= '0;
            wr_sticky_r <= '0;
            rd_start_r  <= '0;
            wr_start_r  <= '0;
            irq_r       <= 1'b0;
        end else begin
            rd_busy_r   <= rd_busy_nxt_s;
            wr_busy_r   <= wr_busy_nxt_s;
            rd_sticky_r <= rd_sticky_nxt_s;
            wr_sticky_r <= wr_sticky_nxt_s;
            rd_start_r  <= rd_start_nxt_s;
            wr_start_r  <= wr_start_nxt_s;
            irq_r       <= irq_nxt_s;
        end
    end

    // Config storage; a direction's words are frozen while that direction is busy
    always_ff @(posedge zynq2gdma_reg_clk or posedge zynq2gdma_reg_rst) begin
        if (zynq2gdma_reg_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_addr_lo_r[c] <= 32'd0;
                rd_addr_hi_r[c] <= '0;
                rd_len_r[c]     <= 32'd0;
                wr_addr_lo_r[c] <= 32'd0;
                wr_addr_hi_r[c] <= '0;
                wr_len_r[c]     <= 32'd0;
            end
            irq_en_r    <= 32'd0;
            speed_div_r <= 32'd0;
            bypass_r    <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_s && sel_s[c]) begin
                    case (off_s)
                        3'd0: if (!rd_busy_r[c]) rd_addr_lo_r[c] <= byte_merge(rd_addr_lo_r[c], wdata_s, reg_bus.zynq2gdma_reg_we);
                        3'd1: if (!rd_busy_r[c]) rd_addr_hi_r[c] <= HI_W'(byte_merge(hi_zext(rd_addr_hi_r[c]), wdata_s, reg_bus.zynq2gdma_reg_we));
                        3'd2: if (!rd_busy_r[c]) rd_len_r[c]     <= byte_merge(rd_len_r[c], wdata_s, reg_bus.zynq2gdma_reg_we);
                        3'd3: if (!wr_busy_r[c]) wr_addr_lo_r[c] <= byte_merge(wr_addr_lo_r[c], wdata_s, reg_bus.zynq2gdma_reg_we);
                        3'd4: if (!wr_busy_r[c]) wr_addr_hi_r[c] <= HI_W'(byte_merge(hi_zext(wr_addr_hi_r[c]), wdata_s, reg_bus.zynq2gdma_reg_we));
                        3'd5: if (!wr_busy_r[c]) wr_len_r[c]     <= byte_merge(wr_len_r[c], wdata_s, reg_bus.zynq2gdma_reg_we);
                        default: ;
                    endcase
                end
            end
            if (wr_s) begin
                case (word_s)
                    10'h080: irq_en_r    <= byte_merge(irq_en_r, wdata_s, reg_bus.zynq2gdma_reg_we) & IRQ_EN_MASK;
                    10'h081: speed_div_r <= byte_merge(speed_div_r, wdata_s, reg_bus.zynq2gdma_reg_we);
                    10'h082: if (reg_bus.zynq2gdma_reg_we[0]) bypass_r <= wdata_s[0];
                    default: ;
                endcase
            end
        end
    end

    // Read mux: selected channel word OR'd with global word; unmapped decodes give 0
    always_comb begin
        chan_word_s = 32'd0;
        rd_mux_s    = 32'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            case (off_s)
                3'd0:    chan_word_s = rd_addr_lo_r[c];
                3'd1:    chan_word_s = hi_zext(rd_addr_hi_r[c]);
                3'd2:    chan_word_s = rd_len_r[c];
                3'd3:    chan_word_s = wr_addr_lo_r[c];
                3'd4:    chan_word_s = hi_zext(wr_addr_hi_r[c]);
                3'd5:    chan_word_s = wr_len_r[c];
                3'd7:    chan_word_s = {28'd0, wr_sticky_r[c], rd_sticky_r[c], wr_busy_r[c], rd_busy_r[c]};
                default: chan_word_s = 32'd0;
            endcase
            rd_mux_s = rd_mux_s | ({32{sel_s[c]}} & chan_word_s);
        end
        case (word_s)
            10'h080: glob_word_s = irq_en_r;
            10'h081: glob_word_s = speed_div_r;
            10'h082: glob_word_s = {31'd0, bypass_r};
            10'h083: glob_word_s = VERSION;
            default: glob_word_s = 32'd0;
        endcase
        rd_mux_s = rd_mux_s | glob_word_s;
    end

    // Read data register; any enabled access (read or write) captures the pre-write word
    always_ff @(posedge zynq2gdma_reg_clk or posedge zynq2gdma_reg_rst) begin
        if (zynq2gdma_reg_rst) begin
            rddata_r <= 32'd0;
        end else if (reg_bus.zynq2gdma_reg_en) begin
            rddata_r <= rd_mux_s;
        end
    end

    // Output packing, straight from registers
    always_comb begin
        gdma_start_rd_addr = '0;
        gdma_start_wr_addr = '0;
        gdma_rd_length     = '0;
        gdma_wr_length     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            gdma_start_rd_addr[c*ADDR_W +: ADDR_W] = {rd_addr_hi_r[c], rd_addr_lo_r[c]};
            gdma_start_wr_addr[c*ADDR_W +: ADDR_W] = {wr_addr_hi_r[c], wr_addr_lo_r[c]};
            gdma_rd_length[c*32 +: 32]             = rd_len_r[c];
            gdma_wr_length[c*32 +: 32]             = wr_len_r[c];
        end
    end

    assign reg_bus.zynq2gdma_reg_rddata = rddata_r;
    assign gdma_rd_start                = rd_start_r;
    assign gdma_wr_start                = wr_start_r;
    assign gdma_speed_divider           = speed_div_r;
    assign gdma_package_bypass          = bypass_r;
    assign gdma_irq                     = irq_r;

endmodule

// File: tb/tb_gdma_reg_bank.sv
// Scoreboard bench for gdma_reg_bank: a 4-channel instance for the main function and a
// 1-channel instance for the narrow-configuration and mid-transfer reset cases.
module tb_gdma_reg_bank;
    localparam int NCH = 4;
    localparam int AW  = 49;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    gdma_reg_if bus0();
    gdma_reg_if bus1();

    logic [NCH*AW-1:0] rd_addr0, wr_addr0;
    logic [NCH*32-1:0] rd_len0, wr_len0;
    logic [NCH-1:0]    rd_start0, wr_start0, rd_done0, wr_done0;
    logic [31:0]       div0;
    logic              byp0, irq0;

    logic [AW-1:0]     rd_addr1, wr_addr1;
    logic [31:0]       rd_len1, wr_len1, div1;
    logic [0:0]        rd_start1, wr_start1, rd_done1, wr_done1;
    logic              byp1, irq1;

    gdma_reg_bank #(.NUM_CH(NCH), .ADDR_W(AW)) dut0 (
        .zynq2gdma_reg_clk(clk), .zynq2gdma_reg_rst(rst0), .reg_bus(bus0),
        .gdma_start_rd_addr(rd_addr0), .gdma_start_wr_addr(wr_addr0),
        .gdma_rd_length(rd_len0), .gdma_wr_length(wr_len0),
        .gdma_rd_start(rd_start0), .gdma_wr_start(wr_start0),
        .gdma_rd_done(rd_done0), .gdma_wr_done(wr_done0),
        .gdma_speed_divider(div0), .gdma_package_bypass(byp0), .gdma_irq(irq0)
    );

    gdma_reg_bank #(.NUM_CH(1), .ADDR_W(AW)) dut1 (
        .zynq2gdma_reg_clk(clk), .zynq2gdma_reg_rst(rst1), .reg_bus(bus1),
        .gdma_start_rd_addr(rd_addr1), .gdma_start_wr_addr(wr_addr1),
        .gdma_rd_length(rd_len1), .gdma_wr_length(wr_len1),
        .gdma_rd_start(rd_start1), .gdma_wr_start(wr_start1),
        .gdma_rd_done(rd_done1), .gdma_wr_done(wr_done1),
        .gdma_speed_divider(div1), .gdma_package_bypass(byp1), .gdma_irq(irq1)
    );

    int          vectors_applied = 0;
    int          miscompares     = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int which, input logic [12:0] a, input logic [31:0] d, input logic [3:0] we);
        if (which == 0) begin
            bus0.zynq2gdma_reg_en = 1'b1; bus0.zynq2gdma_reg_addr = a;
            bus0.zynq2gdma_reg_wrdata = d; bus0.zynq2gdma_reg_we = we;
        end else begin
            bus1.zynq2gdma_reg_en = 1'b1; bus1.zynq2gdma_reg_addr = a;
            bus1.zynq2gdma_reg_wrdata = d; bus1.zynq2gdma_reg_we = we;
        end
    endtask

    task automatic idle_bus();
        bus0.zynq2gdma_reg_en = 1'b0; bus0.zynq2gdma_reg_we = 4'h0;
        bus1.zynq2gdma_reg_en = 1'b0; bus1.zynq2gdma_reg_we = 4'h0;
    endtask

    // Callers are always positioned just after a falling edge
    task automatic wr(input int which, input logic [12:0] a, input logic [31:0] d, input logic [3:0] we);
        drive(which, a, d, we);
        @(negedge clk);
        idle_bus();
    endtask

    task automatic rd(input int which, input logic [12:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] got;
        drive(which, a, 32'd0, 4'h0);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        idle_bus();
        got = (which == 0) ? bus0.zynq2gdma_reg_rddata : bus1.zynq2gdma_reg_rddata;
        check(tag_q.pop_front(), {32'd0, got}, {32'd0, exp_q.pop_front()});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        rd_done0 = '0; wr_done0 = '0; rd_done1 = '0; wr_done1 = '0;
        bus0.zynq2gdma_reg_addr = 13'd0; bus0.zynq2gdma_reg_wrdata = 32'd0;
        bus1.zynq2gdma_reg_addr = 13'd0; bus1.zynq2gdma_reg_wrdata = 32'd0;
        idle_bus();
        @(negedge clk); @(negedge clk);
        check("rst_rddata", {32'd0, bus0.zynq2gdma_reg_rddata}, 64'd0);
        check("rst_irq", {63'd0, irq0}, 64'd0);
        check("rst_rdaddr2", {15'd0, rd_addr0[2*AW +: AW]}, 64'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);

        rd(0, 13'h20C, 32'h0002_0004, "version");

        // 49-bit start address through lo/hi words
        wr(0, 13'h040, 32'hDEAD_BEEF, 4'hF);
        wr(0, 13'h044, 32'h0001_FFFF, 4'hF);
        rd(0, 13'h040, 32'hDEAD_BEEF, "ch2_lo");
        rd(0, 13'h044, 32'h0001_FFFF, "ch2_hi");
        check("ch2_rdaddr_out", {15'd0, rd_addr0[2*AW +: AW]}, 64'h0001_FFFF_DEAD_BEEF);
        wr(0, 13'h024, 32'hFFFF_FFFF, 4'hF);
        rd(0, 13'h024, 32'h0001_FFFF, "hi_mask");
        rd(0, 13'h1040, 32'hDEAD_BEEF, "addr12_ignored");

        // start pulse, busy status, start-while-busy ignored
        wr(0, 13'h018, 32'h1, 4'h1);
        check("start_pulse", {60'd0, rd_start0}, 64'h1);
        @(negedge clk);
        check("start_one_cycle", {60'd0, rd_start0}, 64'h0);
        rd(0, 13'h01C, 32'h1, "status_busy");
        wr(0, 13'h018, 32'h1, 4'h1);
        check("start_busy_ignored", {60'd0, rd_start0}, 64'h0);
        rd(0, 13'h018, 32'h0, "ctrl_reads0");

        // config write while busy is dropped
        wr(0, 13'h008, 32'h100, 4'hF);
        rd(0, 13'h008, 32'h0, "len_busy_drop");

        // done, sticky, irq, W1C
        wr(0, 13'h200, 32'h1, 4'hF);
        rd_done0[0] = 1'b1; @(negedge clk); rd_done0[0] = 1'b0;
        check("irq_latency", {63'd0, irq0}, 64'd0);
        @(negedge clk);
        check("irq_set", {63'd0, irq0}, 64'd1);
        rd(0, 13'h01C, 32'h4, "status_done");
        wr(0, 13'h01C, 32'h4, 4'h1);
        @(negedge clk);
        check("irq_clr", {63'd0, irq0}, 64'd0);
        drive(0, 13'h01C, 32'h4, 4'h1); rd_done0[0] = 1'b1;
        @(negedge clk);
        idle_bus(); rd_done0[0] = 1'b0;
        rd(0, 13'h01C, 32'h4, "w1c_vs_done");

        // config write accepted once idle; single byte lane
        wr(0, 13'h008, 32'h100, 4'hF);
        rd(0, 13'h008, 32'h100, "len_idle");
        check("len_out", {32'd0, rd_len0[31:0]}, 64'h100);
        wr(0, 13'h008, 32'hAABB_CCDD, 4'b0100);
        rd(0, 13'h008, 32'h00BB_0100, "byte_lane");

        // done and start in the same cycle
        wr(0, 13'h01C, 32'h4, 4'h1);
        wr(0, 13'h018, 32'h1, 4'h1);
        check("start_again", {60'd0, rd_start0}, 64'h1);
        drive(0, 13'h018, 32'h1, 4'h1); rd_done0[0] = 1'b1;
        @(negedge clk);
        idle_bus(); rd_done0[0] = 1'b0;
        check("start_with_done", {60'd0, rd_start0}, 64'h1);
        rd(0, 13'h01C, 32'h5, "status_busy_done");

        // wr direction and its irq enable
        wr(0, 13'h200, 32'h0002_0000, 4'hF);
        @(negedge clk);
        check("irq_masked", {63'd0, irq0}, 64'd0);
        wr(0, 13'h038, 32'h2, 4'h1);
        check("wr_start_pulse", {60'd0, wr_start0}, 64'h2);
        rd(0, 13'h03C, 32'h2, "wr_busy");
        wr_done0[1] = 1'b1; @(negedge clk); wr_done0[1] = 1'b0;
        @(negedge clk);
        check("irq_wr", {63'd0, irq0}, 64'd1);
        rd(0, 13'h03C, 32'h8, "wr_sticky");

        // unmapped, out of range, globals, read-only
        rd(0, 13'h210, 32'h0, "unmapped");
        wr(0, 13'h080, 32'hFFFF_FFFF, 4'hF);
        rd(0, 13'h080, 32'h0, "ch4_oob");
        wr(0, 13'h204, 32'h1234_5678, 4'hF);
        rd(0, 13'h204, 32'h1234_5678, "speed_rd");
        check("speed_out", {32'd0, div0}, 64'h1234_5678);
        wr(0, 13'h208, 32'h3, 4'hF);
        rd(0, 13'h208, 32'h1, "bypass_rd");
        check("bypass_out", {63'd0, byp0}, 64'd1);
        wr(0, 13'h20C, 32'hFFFF_FFFF, 4'hF);
        rd(0, 13'h20C, 32'h0002_0004, "version_ro");
        wr(0, 13'h200, 32'hFFFF_FFFF, 4'hF);
        rd(0, 13'h200, 32'h000F_000F, "irq_en_mask");
        @(negedge clk);
        check("rddata_hold", {32'd0, bus0.zynq2gdma_reg_rddata}, 64'h000F_000F);
        wr(0, 13'h204, 32'h1, 4'hF);
        check("wr_prevalue", {32'd0, bus0.zynq2gdma_reg_rddata}, 64'h1234_5678);
        rd(0, 13'h207, 32'h1, "low_bits_ignored");

        // async reset mid-transfer, then done after reset only sets sticky
        wr(0, 13'h058, 32'h3, 4'h1);
        check("ch2_both_start", {56'd0, wr_start0, rd_start0}, 64'h44);
        #2 rst0 = 1'b1;
        #1;
        check("arst_starts", {56'd0, wr_start0, rd_start0}, 64'h0);
        check("arst_rddata", {32'd0, bus0.zynq2gdma_reg_rddata}, 64'd0);
        check("arst_div", {32'd0, div0}, 64'd0);
        check("arst_irq", {63'd0, irq0}, 64'd0);
        @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);
        rd(0, 13'h05C, 32'h0, "status_after_rst");
        rd(0, 13'h040, 32'h0, "lo_after_rst");
        rd_done0[2] = 1'b1; @(negedge clk); rd_done0[2] = 1'b0;
        rd(0, 13'h05C, 32'h4, "done_after_rst");

        // single-channel instance
        wr(1, 13'h020, 32'h0000_FFFF, 4'hF);
        rd(1, 13'h020, 32'h0, "n1_word8");
        rd(1, 13'h20C, 32'h0002_0001, "n1_version");
        wr(1, 13'h000, 32'h55, 4'hF);
        wr(1, 13'h008, 32'h40, 4'hF);
        wr(1, 13'h018, 32'h1, 4'h1);
        check("n1_start", {63'd0, rd_start1}, 64'd1);
        rd(1, 13'h01C, 32'h1, "n1_busy");
        #2 rst1 = 1'b1;
        #1;
        check("n1_arst_addr", {15'd0, rd_addr1}, 64'd0);
        check("n1_arst_len", {32'd0, rd_len1}, 64'd0);
        check("n1_arst_rddata", {32'd0, bus1.zynq2gdma_reg_rddata}, 64'd0);
        check("n1_arst_pulse_irq", {62'd0, rd_start1, irq1}, 64'd0);
        @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);
        rd(1, 13'h01C, 32'h0, "n1_status_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end
endmodule
